rs_multi: RTL

- Parametrised, multi-entry reservation station for the R10K-style out-of-order core.
- Sits between dispatch (decode/rename) and the functional units. It accepts one renamed instruction per cycle into any free entry.
- Tracks source-tag readiness via CDB broadcast.
- Issues up to one instruction per FU class per cycle, oldest-ready first, under a valid/ready handshake.
- Replaces the fixed one-entry-per-FU table with a depth- and class-parametrised pool, adding flush support.

---
 rtl/rs_multi_pkg.sv | 16 +
 rtl/rs_multi_age_select.sv | 23 ++
 rtl/rs_multi.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rs_multi_pkg.sv
// Shared defaults and FU class encoding for the multi-entry reservation station.
package rs_multi_pkg;

    localparam int unsigned RS_DEPTH       = 8;
    localparam int unsigned NUM_FU_CLASSES = 4;
    localparam int unsigned RS_TAG_W       = 6;
    localparam int unsigned RS_PL_W        = 64;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_LD   = 2'd1,
        FU_ST   = 2'd2,
        FU_MULT = 2'd3
    } fu_class_e;

endpackage

// File: rtl/rs_multi_age_select.sv
// Oldest-first picker: grants the eligible entry that no other eligible entry is older than.
module rs_age_select #(
    parameter int unsigned DEPTH = 8
) (
    input  logic [DEPTH-1:0]            elig_i,
    input  logic [DEPTH-1:0][DEPTH-1:0] age_i,
    output logic [DEPTH-1:0]            grant_o,
    output logic                        any_o
);

    always_comb begin
        grant_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            grant_o[i] = elig_i[i];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (elig_i[j] && age_i[j][i]) grant_o[i] = 1'b0;
            end
        end
    end

    assign any_o = |grant_o;

endmodule

// File: rtl/rs_multi.sv
// Multi-entry reservation station: CDB wakeup, per-class oldest-ready issue, flush.
module rs_multi
    import rs_multi_pkg::*;
#(
    parameter  int unsigned DEPTH  = RS_DEPTH,
    parameter  int unsigned NUM_FU = NUM_FU_CLASSES,
    parameter  int unsigned TAG_W  = RS_TAG_W,
    parameter  int unsigned PL_W   = RS_PL_W,
    localparam int unsigned FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     disp_valid,
    input  logic [FU_W-1:0]          disp_fu,
    input  logic [TAG_W-1:0]         disp_T,
    input  logic [TAG_W-1:0]         disp_T1,
    input  logic [TAG_W-1:0]         disp_T2,
    input  logic                     disp_T1_rdy,
    input  logic                     disp_T2_rdy,
    input  logic                     disp_T1_used,
    input  logic                     disp_T2_used,
    input  logic [PL_W-1:0]          disp_payload,
    output logic                     disp_ready,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [NUM_FU-1:0]        fu_ready,
    input  logic                     flush,
    output logic [NUM_FU-1:0]        issue_valid,
    output logic [NUM_FU*TAG_W-1:0]  issue_T,
    output logic [NUM_FU*PL_W-1:0]   issue_payload,
    output logic [CNT_W-1:0]         free_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic             valid;
        logic [FU_W-1:0]  fu;
        logic [TAG_W-1:0] t;
        logic [TAG_W-1:0] t1;
        logic [TAG_W-1:0] t2;
        logic             r1;
        logic             r2;
        logic [PL_W-1:0]  payload;
    } entry_t;

    entry_t                      ent_q [DEPTH];
    entry_t                      ent_d [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic [DEPTH-1:0] elig  [NUM_FU];
    logic [DEPTH-1:0] grant [NUM_FU];
    logic             sel_any [NUM_FU];
    logic [DEPTH-1:0] freed;
    logic [CNT_W-1:0] n_issued;
    logic [CNT_W-1:0] n_free_pop;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_hit;
    logic             alloc_en;
    logic             r1_new, r2_new;

    assign free_count = cnt_q;
    assign disp_ready = (cnt_q != '0);

    always_comb begin
        for (int unsigned c = 0; c < NUM_FU; c++) begin
            elig[c] = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                elig[c][i] = ent_q[i].valid && ent_q[i].r1 && ent_q[i].r2
                             && (ent_q[i].fu == FU_W'(c));
            end
        end
    end

    for (genvar c = 0; c < NUM_FU; c++) begin : g_sel
        rs_age_select #(.DEPTH(DEPTH)) u_sel (
            .elig_i  (elig[c]),
            .age_i   (age_q),
            .grant_o (grant[c]),
            .any_o   (sel_any[c])
        );
    end

    // Issue mux; fu_ready only gates the free, never issue_valid itself.
    always_comb begin
        issue_valid   = '0;
        issue_T       = '0;
        issue_payload = '0;
        freed         = '0;
        n_issued      = '0;
        for (int unsigned c = 0; c < NUM_FU; c++) begin
            issue_valid[c] = sel_any[c] && !flush && reset;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (grant[c][i]) begin
                    issue_T[c*TAG_W +: TAG_W]      = ent_q[i].t;
                    issue_payload[c*PL_W +: PL_W]  = ent_q[i].payload;
                end
            end
            if (issue_valid[c] && fu_ready[c]) begin
                freed    = freed | grant[c];
                n_issued = n_issued + CNT_W'(1);
            end
        end
    end

    always_comb begin
        alloc_idx  = '0;
        alloc_hit  = 1'b0;
        n_free_pop = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!ent_q[i].valid) begin
                n_free_pop = n_free_pop + CNT_W'(1);
                if (!alloc_hit) begin
                    alloc_hit = 1'b1;
                    alloc_idx = IDX_W'(i);
                end
            end
        end
    end

    assign alloc_en = disp_valid && disp_ready && !flush;
    assign r1_new   = disp_T1_rdy || !disp_T1_used || (cdb_valid && cdb_tag == disp_T1);
    assign r2_new   = disp_T2_rdy || !disp_T2_used || (cdb_valid && cdb_tag == disp_T2);

    always_comb begin
        ent_d = ent_q;
        age_d = age_q;
        cnt_d = cnt_q - CNT_W'(alloc_en) + n_issued;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cdb_valid && ent_q[i].valid) begin
                if (ent_q[i].t1 == cdb_tag) ent_d[i].r1 = 1'b1;
                if (ent_q[i].t2 == cdb_tag) ent_d[i].r2 = 1'b1;
            end
            if (freed[i]) begin
                ent_d[i].valid = 1'b0;
                age_d[i]       = '0;
                for (int unsigned j = 0; j < DEPTH; j++) age_d[j][i] = 1'b0;
            end
        end
        // Frees are applied first so the new entry is only younger than survivors.
        if (alloc_en) begin
            ent_d[alloc_idx] = '{valid: 1'b1, fu: disp_fu, t: disp_T, t1: disp_T1,
                                 t2: disp_T2, r1: r1_new, r2: r2_new, payload: disp_payload};
            for (int unsigned j = 0; j < DEPTH; j++) begin
                age_d[j][alloc_idx] = ent_d[j].valid && (j != 32'(alloc_idx));
            end
            age_d[alloc_idx] = '0;
        end
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
            age_d = '0;
            cnt_d = CNT_W'(DEPTH);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
            age_q <= '0;
            cnt_q <= CNT_W'(DEPTH);
        end else begin
            ent_q <= ent_d;
            age_q <= age_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) assert (cnt_q == n_free_pop);
    end

endmodule
